// File: rtl/btn_conditioner.sv
//------------------------------------------------------------------------------
// Module      : btn_conditioner
// Description : Per-channel synchronizer, debounce FSM and press/release pulses
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic             s1_q;
        logic             s2_q;
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             press_d;
        logic             rel_q;
        logic             rel_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_LOW: begin
                    if (s2_q) begin
                        state_d = ST_WAIT_HIGH;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!s2_q) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!s2_q) begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOW: begin
                    if (s2_q) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end
            endcase

            // Outputs are decoded from the next state so they register on the same edge as the transition.
            level_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
            press_d = (state_q == ST_WAIT_HIGH) && (state_d == ST_HIGH);
            rel_d   = (state_q == ST_WAIT_LOW) && (state_d == ST_LOW);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= ST_LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                s1_q    <= btn_raw[i];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
    end

endmodule

`default_nettype wire
